// File: rtl/memory_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package memory_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

endpackage

// File: rtl/memory_arbiter_if.sv
// Per-requester request/response bundle; the arbiter takes the slave side.
interface memory_arbiter_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output we, output addr, output wdata,
                    input  done, input  rdata);
    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output done, output rdata);
endinterface

// File: rtl/memory_arbiter_rr.sv
// Two-way round-robin arbiter: combinational one-hot grant plus last-grant flop.
module rr_arbiter2
    import memory_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_a_i,
    input  logic       req_b_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    owner_e last_q, last_d;

    always_comb begin
        gnt_o = '0;
        if (req_a_i && req_b_i) begin
            gnt_o = (last_q == OWN_B) ? 2'b01 : 2'b10;
        end else if (req_a_i) begin
            gnt_o = 2'b01;
        end else if (req_b_i) begin
            gnt_o = 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept_i && (gnt_o != '0)) begin
            last_d = gnt_o[1] ? OWN_B : OWN_A;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= OWN_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates two requesters onto one latch-based memory port and sequences
// SETUP -> WRITE/READ -> DONE with fully registered outputs.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    memory_arbiter_if.slave   a_if,
    memory_arbiter_if.slave   b_if,
    output logic              mem_activate_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    output logic [ADDR_W-1:0] mem_addrin_o,
    output logic [ADDR_W-1:0] mem_addrout_o,
    output logic [DATA_W-1:0] mem_datain_o,
    input  logic [DATA_W-1:0] mem_dataout_i,
    output logic              busy_o
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              act_q, act_d, wr_q, wr_d, rd_q, rd_d, busy_q, busy_d;
    logic [ADDR_W-1:0] addrin_q, addrin_d, addrout_q, addrout_d;
    logic [DATA_W-1:0] datain_q, datain_d;
    logic              done_a_q, done_a_d, done_b_q, done_b_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic [1:0]        gnt;
    logic              accept;

    rr_arbiter2 u_rr (
        .clk_i    (clk_i),
        .rst_ni   (reset_ni),
        .req_a_i  (a_if.req),
        .req_b_i  (b_if.req),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt != '0) begin
                    accept  = 1'b1;
                    owner_d = gnt[1] ? OWN_B : OWN_A;
                    we_d    = gnt[1] ? b_if.we    : a_if.we;
                    addr_d  = gnt[1] ? b_if.addr  : a_if.addr;
                    wdata_d = gnt[1] ? b_if.wdata : a_if.wdata;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = we_q ? ST_WRITE : ST_READ;
                cnt_d   = 3'(RD_LATENCY - 1);
            end
            ST_WRITE: state_d = ST_DONE;
            ST_READ: begin
                if (cnt_q == '0) begin
                    if (owner_q == OWN_A) rdata_a_d = mem_dataout_i;
                    else                  rdata_b_d = mem_dataout_i;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        act_d     = (state_d == ST_SETUP) || (state_d == ST_WRITE) || (state_d == ST_READ);
        wr_d      = (state_d == ST_WRITE);
        rd_d      = (state_d == ST_READ);
        busy_d    = (state_d != ST_IDLE);
        done_a_d  = (state_d == ST_DONE) && (owner_d == OWN_A);
        done_b_d  = (state_d == ST_DONE) && (owner_d == OWN_B);
        addrin_d  = addrin_q;
        addrout_d = addrout_q;
        datain_d  = datain_q;
        if (state_d == ST_SETUP) begin
            addrin_d  = addr_d;
            addrout_d = addr_d;
            datain_d  = wdata_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_A;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            act_q     <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
            addrin_q  <= '0;
            addrout_q <= '0;
            datain_q  <= '0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
            addrin_q  <= addrin_d;
            addrout_q <= addrout_d;
            datain_q  <= datain_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign a_if.done      = done_a_q;
    assign a_if.rdata     = rdata_a_q;
    assign b_if.done      = done_b_q;
    assign b_if.rdata     = rdata_b_q;
    assign mem_activate_o = act_q;
    assign mem_write_o    = wr_q;
    assign mem_read_o     = rd_q;
    assign mem_addrin_o   = addrin_q;
    assign mem_addrout_o  = addrout_q;
    assign mem_datain_o   = datain_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural 16x8 memory model.
module tb_memory_arbiter;

    logic       clk;
    logic       rst_n;
    logic       mem_activate, mem_write, mem_read, busy;
    logic [3:0] mem_addrin, mem_addrout;
    logic [7:0] mem_datain, mem_dataout;
    logic [7:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;
    int mutex_viol = 0;

    int         op_lat, op_nw, op_nr, op_other;
    logic [3:0] op_waddr;
    logic [7:0] op_wdat, op_rd;
    logic       d_first_b;
    int         d_gap;
    logic [7:0] d_a_rd, d_b_rd;

    memory_arbiter_if #(.ADDR_W(4), .DATA_W(8)) a_if ();
    memory_arbiter_if #(.ADDR_W(4), .DATA_W(8)) b_if ();

    memory_arbiter #(.ADDR_W(4), .DATA_W(8), .RD_LATENCY(2)) dut (
        .clk_i          (clk),
        .reset_ni       (rst_n),
        .a_if           (a_if),
        .b_if           (b_if),
        .mem_activate_o (mem_activate),
        .mem_write_o    (mem_write),
        .mem_read_o     (mem_read),
        .mem_addrin_o   (mem_addrin),
        .mem_addrout_o  (mem_addrout),
        .mem_datain_o   (mem_datain),
        .mem_dataout_i  (mem_dataout),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_activate && mem_write) mem[mem_addrin] <= mem_datain;
    end
    assign mem_dataout = mem[mem_addrout];

    always @(negedge clk) begin
        if (mem_write && mem_read) mutex_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // side: 0 = A, 1 = B. Issued from an IDLE cycle; ends on the done cycle.
    task automatic run_op(input logic side, input logic we, input logic [3:0] addr,
                          input logic [7:0] wdata);
        logic got;
        @(negedge clk);
        if (!side) begin
            a_if.req = 1'b1; a_if.we = we; a_if.addr = addr; a_if.wdata = wdata;
        end else begin
            b_if.req = 1'b1; b_if.we = we; b_if.addr = addr; b_if.wdata = wdata;
        end
        got = 1'b0; op_lat = 0; op_nw = 0; op_nr = 0; op_other = 0;
        op_waddr = '0; op_wdat = '0; op_rd = '0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (mem_write) begin
                op_nw++; op_waddr = mem_addrin; op_wdat = mem_datain;
            end
            if (mem_read) op_nr++;
            if (side ? a_if.done : b_if.done) op_other = 1;
            if (side ? b_if.done : a_if.done) begin
                got = 1'b1; op_lat = i;
                op_rd = side ? b_if.rdata : a_if.rdata;
            end
        end
        if (!got) check("op_timeout", 32'd0, 32'd1);
        a_if.req = 1'b0;
        b_if.req = 1'b0;
    endtask

    task automatic run_dual(input logic a_we, input logic [3:0] a_ad, input logic [7:0] a_wd,
                            input logic b_we, input logic [3:0] b_ad, input logic [7:0] b_wd);
        logic a_got, b_got;
        @(negedge clk);
        a_if.req = 1'b1; a_if.we = a_we; a_if.addr = a_ad; a_if.wdata = a_wd;
        b_if.req = 1'b1; b_if.we = b_we; b_if.addr = b_ad; b_if.wdata = b_wd;
        a_got = 1'b0; b_got = 1'b0; d_first_b = 1'b0; d_gap = 0;
        d_a_rd = '0; d_b_rd = '0;
        for (int i = 0; i < 40 && !(a_got && b_got); i++) begin
            @(negedge clk);
            if (a_if.done) begin
                a_got = 1'b1; d_a_rd = a_if.rdata; a_if.req = 1'b0;
            end
            if (b_if.done) begin
                if (!a_got) d_first_b = 1'b1;
                b_got = 1'b1; d_b_rd = b_if.rdata; b_if.req = 1'b0;
            end
            if ((a_got ^ b_got) && !busy) d_gap++;
        end
        if (!(a_got && b_got)) check("dual_timeout", 32'd0, 32'd1);
        a_if.req = 1'b0;
        b_if.req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.wdata = '0;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_act", mem_activate, 0);
        check("rst_wr_rd", {mem_write, mem_read}, 0);
        check("rst_done", {a_if.done, b_if.done}, 0);
        check("rst_rdata", {a_if.rdata, b_if.rdata}, 0);
        check("rst_addr_data", {mem_addrin, mem_addrout, mem_datain}, 0);
        rst_n = 1'b1;

        // A write 0xA5 to 3
        run_op(1'b0, 1'b1, 4'h3, 8'hA5);
        check("wr_lat", op_lat, 3);
        check("wr_nw", op_nw, 1);
        check("wr_addr", op_waddr, 4'h3);
        check("wr_data", op_wdat, 8'hA5);
        check("wr_nr", op_nr, 0);
        check("wr_b_done", op_other, 0);

        // B read 3
        run_op(1'b1, 1'b0, 4'h3, 8'h00);
        check("rd_lat", op_lat, 4);
        check("rd_data", op_rd, 8'hA5);
        check("rd_nr", op_nr, 2);
        check("rd_nw", op_nw, 0);

        // Alternation: last_grant=B so A first in both rounds
        run_dual(1'b1, 4'h0, 8'h11, 1'b1, 4'h6, 8'h22);
        check("alt1_first_a", d_first_b, 0);
        check("alt1_gap", d_gap >= 1, 1);
        run_dual(1'b0, 4'h0, 8'h00, 1'b0, 4'h6, 8'h00);
        check("alt2_first_a", d_first_b, 0);
        check("alt2_gap", d_gap >= 1, 1);
        check("alt2_a_rd", d_a_rd, 8'h11);
        check("alt2_b_rd", d_b_rd, 8'h22);

        // Same-address race, last_grant=B: write lands first
        run_dual(1'b1, 4'hF, 8'h5A, 1'b0, 4'hF, 8'h00);
        check("race1_first_a", d_first_b, 0);
        check("race1_b_rd", d_b_rd, 8'h5A);
        run_op(1'b0, 1'b0, 4'hF, 8'h00);
        check("race_prep_rd", op_rd, 8'h5A);
        check("race_prep_rdata_hold", b_if.rdata, 8'h5A);
        // last_grant=A now: read goes first and sees the old value
        run_dual(1'b1, 4'hF, 8'hC3, 1'b0, 4'hF, 8'h00);
        check("race2_first_b", d_first_b, 1);
        check("race2_b_rd", d_b_rd, 8'h5A);
        run_op(1'b0, 1'b0, 4'hF, 8'h00);
        check("race2_after", op_rd, 8'hC3);

        // Reset during READ with counter=1
        @(negedge clk);
        a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 4'h3;
        @(negedge clk);
        @(negedge clk);
        check("mid_in_read", mem_read, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_act_rd", {mem_activate, mem_read, mem_write}, 0);
        check("mid_addr", {mem_addrin, mem_addrout, mem_datain}, 0);
        check("mid_rdata", {a_if.rdata, b_if.rdata}, 0);
        check("mid_done", {a_if.done, b_if.done}, 0);
        a_if.req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_no_done", {a_if.done, b_if.done}, 0);
        end
        rst_n = 1'b1;
        run_op(1'b0, 1'b0, 4'h0, 8'h00);
        check("post_rst_lat", op_lat, 4);
        check("post_rst_rd", op_rd, 8'h11);

        // Full address sweep
        for (int i = 0; i < 16; i++) begin
            run_op(1'b0, 1'b1, 4'(i), 8'(i) ^ 8'h3C);
        end
        for (int i = 0; i < 16; i++) begin
            run_op(1'b1, 1'b0, 4'(i), 8'h00);
            check($sformatf("sweep_rd_%0d", i), op_rd, 8'(i) ^ 8'h3C);
        end
        check("mutex", mutex_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
